fifo: RTL and testbench

FIFO -- requirements
Module: fifo

---
 rtl/fifo_if.sv | 34 +++
 rtl/fifo.sv | 88 ++++++++
 tb/tb_fifo.sv | 126 ++++++++++++
 3 files changed

// File: rtl/fifo_if.sv
// Handshake bundle for the fifo block: push/pop requests, read data and status flags.
// With FIFO_ERR_FLAGS_EN defined the bundle also carries the sticky overflow/underflow flags.
interface fifo_if #(
   parameter int BITS = 4
);
   logic            wr_en;
   logic [BITS-1:0] wr_data;
   logic            rd_en;
   logic [BITS-1:0] rd_data;
   logic            full;
   logic            empty;
`ifdef FIFO_ERR_FLAGS_EN
   logic            overflow;
   logic            underflow;

   modport master (
      output wr_en, wr_data, rd_en,
      input  rd_data, full, empty, overflow, underflow
   );
   modport slave (
      input  wr_en, wr_data, rd_en,
      output rd_data, full, empty, overflow, underflow
   );
`else
   modport master (
      output wr_en, wr_data, rd_en,
      input  rd_data, full, empty
   );
   modport slave (
      input  wr_en, wr_data, rd_en,
      output rd_data, full, empty
   );
`endif
endinterface

// File: rtl/fifo.sv
// Synchronous FIFO, SIZE x BITS register storage, registered read data with 1-cycle latency.
// Optional sticky overflow/underflow flags are enabled by defining FIFO_ERR_FLAGS_EN.
module fifo #(
   parameter int BITS = 4,
   parameter int SIZE = 4
) (
   input  logic   clk,
   input  logic   rst,
   fifo_if.slave  bus
);
   localparam int PW = $clog2(SIZE);
   localparam int CW = $clog2(SIZE) + 1;
   localparam logic [PW-1:0] LAST  = PW'(SIZE - 1);
   localparam logic [CW-1:0] DEPTH = CW'(SIZE);

   logic [BITS-1:0] r_mem [SIZE];
   logic [PW-1:0]   r_wptr;
   logic [PW-1:0]   r_rptr;
   logic [CW-1:0]   r_count;
   logic [BITS-1:0] r_rd_data;

   logic w_full;
   logic w_empty;
   logic w_push;
   logic w_pop;

   // A push while full is still accepted when a pop frees a slot on the same edge.
   always_comb begin
      w_full  = (r_count == DEPTH);
      w_empty = (r_count == '0);
      w_pop   = bus.rd_en && !w_empty;
      w_push  = bus.wr_en && (!w_full || bus.rd_en);
   end

   always_ff @(posedge clk) begin
      if (!rst && w_push) begin
         r_mem[r_wptr] <= bus.wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wptr    <= '0;
         r_rptr    <= '0;
         r_count   <= '0;
         r_rd_data <= '0;
      end else begin
         if (w_push) begin
            r_wptr <= (r_wptr == LAST) ? '0 : r_wptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_data <= r_mem[r_rptr];
            r_rptr    <= (r_rptr == LAST) ? '0 : r_rptr + 1'b1;
         end
         if (w_push && !w_pop) begin
            r_count <= r_count + 1'b1;
         end else if (w_pop && !w_push) begin
            r_count <= r_count - 1'b1;
         end
      end
   end

   assign bus.rd_data = r_rd_data;
   assign bus.full    = w_full;
   assign bus.empty   = w_empty;

`ifdef FIFO_ERR_FLAGS_EN
   logic r_overflow;
   logic r_underflow;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         if (bus.wr_en && w_full && !bus.rd_en) begin
            r_overflow <= 1'b1;
         end
         if (bus.rd_en && w_empty) begin
            r_underflow <= 1'b1;
         end
      end
   end

   assign bus.overflow  = r_overflow;
   assign bus.underflow = r_underflow;
`endif
endmodule

// File: tb/tb_fifo.sv
// Self-checking bench for fifo: directed scenarios then randomized traffic against a queue model.
module tb_fifo;
   localparam int BITS = 4;
   localparam int SIZE = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;

   fifo_if #(.BITS(BITS)) bus ();

   fifo #(.BITS(BITS), .SIZE(SIZE)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   logic [BITS-1:0] mq[$];
   logic [BITS-1:0] m_rd = '0;
   logic            m_ovf = 1'b0;
   logic            m_unf = 1'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h at t=%0t", tag, got, exp, $time);
      end
   endtask

   // One clock: drive inputs, let the edge happen, advance the model, compare outputs.
   task automatic step(input logic wr, input logic [BITS-1:0] d, input logic rd, input logic r);
      bit was_full;
      bit was_empty;
      bus.wr_en   = wr;
      bus.wr_data = d;
      bus.rd_en   = rd;
      rst         = r;
      @(posedge clk);
      was_full  = (mq.size() == SIZE);
      was_empty = (mq.size() == 0);
      if (r) begin
         mq.delete();
         m_rd  = '0;
         m_ovf = 1'b0;
         m_unf = 1'b0;
      end else begin
         if (wr && was_full && !rd) m_ovf = 1'b1;
         if (rd && was_empty)       m_unf = 1'b1;
         if (rd && !was_empty)      m_rd = mq.pop_front();
         if (wr && (!was_full || rd)) mq.push_back(d);
      end
      #1;
      check("rd_data", 32'(bus.rd_data), 32'(m_rd));
      check("full",    32'(bus.full),    32'(mq.size() == SIZE));
      check("empty",   32'(bus.empty),   32'(mq.size() == 0));
`ifdef FIFO_ERR_FLAGS_EN
      check("overflow",  32'(bus.overflow),  32'(m_ovf));
      check("underflow", 32'(bus.underflow), 32'(m_unf));
`endif
   endtask

   initial begin
      logic [BITS-1:0] fill [4];
      fill[0] = 4'hd; fill[1] = 4'he; fill[2] = 4'ha; fill[3] = 4'h4;
      bus.wr_en = 1'b0; bus.rd_en = 1'b0; bus.wr_data = '0;
      #2;

      // reset state
      step(1'b1, 4'h9, 1'b1, 1'b1);
      check("reset_rd_data", 32'(bus.rd_data), 32'h0);
      check("reset_empty",   32'(bus.empty),   32'h1);

      // fill then drain
      for (int i = 0; i < 4; i++) step(1'b1, fill[i], 1'b0, 1'b0);
      check("fill_full", 32'(bus.full), 32'h1);
      // push while full is dropped
      step(1'b1, 4'h7, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         step(1'b0, '0, 1'b1, 1'b0);
         check("drain_order", 32'(bus.rd_data), 32'(fill[i]));
      end
      check("drain_empty", 32'(bus.empty), 32'h1);
      // pop while empty keeps rd_data
      step(1'b0, '0, 1'b1, 1'b0);
      check("underflow_hold", 32'(bus.rd_data), 32'h4);

      // wrap with simultaneous push+pop while full
      step(1'b0, '0, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) step(1'b1, 4'(i + 1), 1'b0, 1'b0);
      for (int i = 0; i < 2; i++) step(1'b0, '0, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b1, 4'(i + 8), 1'b0, 1'b0);
      step(1'b1, 4'hc, 1'b1, 1'b0);
      check("wrap_full_stays", 32'(bus.full), 32'h1);
      check("wrap_oldest_out", 32'(bus.rd_data), 32'h3);
      for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, 1'b0);
      check("wrap_last_word", 32'(bus.rd_data), 32'hc);
      // push+pop while empty performs only the push
      step(1'b1, 4'h5, 1'b1, 1'b0);
      check("empty_pushpop_rd", 32'(bus.rd_data), 32'hc);

      // reset mid-operation
      step(1'b1, 4'h1, 1'b0, 1'b0);
      step(1'b1, 4'h2, 1'b0, 1'b1);
      check("midrst_rd_data", 32'(bus.rd_data), 32'h0);
      step(1'b1, 4'hb, 1'b0, 1'b0);
      step(1'b0, '0, 1'b1, 1'b0);
      check("midrst_new_word", 32'(bus.rd_data), 32'hb);
      check("midrst_empty",    32'(bus.empty),   32'h1);

      // randomized traffic with shifting push/pop bias
      for (int i = 0; i < 3000; i++) begin
         int unsigned wb;
         wb = ((i / 200) % 2 == 0) ? 70 : 30;
         step($urandom_range(0, 99) < wb, 4'($urandom), $urandom_range(0, 99) < (100 - wb),
              $urandom_range(0, 149) == 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
